// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole game logic.
package mole_pkg;

  localparam int         N_HOLES    = 9;
  localparam logic [8:0] LFSR_SEED  = 9'h1A5;
  localparam int         LFSR_TAP_A = 8;
  localparam int         LFSR_TAP_B = 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER
  } state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 9-bit Fibonacci LFSR (x^9+x^5+1), free-running every cycle from a non-zero seed.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] q
);

  logic [8:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= {r_q[7:0], r_q[LFSR_TAP_A] ^ r_q[LFSR_TAP_B]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game logic: spawns, ages and scores moles over a timed round.
// Optional build macro MISS_PENALTY_EN: hits on vacant holes subtract from the score.
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int MOLE_LIFE  = 3,
  parameter int GAME_TICKS = 60,
  parameter int SCORE_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         hit,
  output logic [8:0]         map,
  output logic [SCORE_W-1:0] score,
  output logic               playing,
  output logic               game_over
);

  localparam int CNT_W     = $clog2(TICK_DIV);
  localparam int RND_W     = $clog2(GAME_TICKS + 1);
  localparam int LIFE_W    = $clog2(MOLE_LIFE + 1);
  localparam int SCORE_MAX = 2**SCORE_W - 1;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [RND_W-1:0]     r_rnd;
  logic [N_HOLES-1:0]   r_map;
  logic [SCORE_W-1:0]   r_score;

  logic [8:0]           w_lfsr;
  logic                 w_lfsr_unused;
  logic [3:0]           w_k;
  logic                 w_enter, w_tick, w_last, w_spawn_ok;
  logic [N_HOLES-1:0]   w_hits, w_miss, w_survive, w_spawn, w_map_next;
  logic [SCORE_W-1:0]   w_score_next;
  int                   w_sum;

  mole_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Only the low nibble selects a hole; the upper bits just carry the sequence.
  assign w_lfsr_unused = ^w_lfsr[8:4];
  assign w_k           = w_lfsr[3:0];

  assign w_enter    = (r_state != PLAY) && start;
  assign w_tick     = (r_state == PLAY) && (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_last     = w_tick && (r_rnd == RND_W'(1));
  assign w_spawn_ok = w_tick && !w_last && (w_k < 4'd9);
  assign w_hits     = hit & r_map;
  assign w_miss     = hit & ~r_map;

  generate
    for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_hole
      logic [LIFE_W-1:0] r_life;
      logic              w_expire;

      assign w_expire      = w_tick && r_map[gi] && (r_life == LIFE_W'(1));
      // A hit always beats an expiry, and a hit hole counts as vacant for spawning.
      assign w_survive[gi] = r_map[gi] && !hit[gi] && !w_expire;
      assign w_spawn[gi]   = w_spawn_ok && (w_k == 4'(gi)) && !w_survive[gi];

      always_ff @(posedge clk) begin
        if (rst || w_enter) begin
          r_life <= '0;
        end else if (w_spawn[gi]) begin
          r_life <= LIFE_W'(MOLE_LIFE);
        end else if (w_tick && r_map[gi]) begin
          r_life <= r_life - 1'b1;
        end
      end
    end
  endgenerate

  assign w_map_next = w_last ? '0 : (w_survive | w_spawn);

  always_comb begin
    w_sum = int'(r_score) + int'(popcount9(w_hits));
`ifdef MISS_PENALTY_EN
    w_sum = w_sum - int'(popcount9(w_miss));
    if (w_sum < 0) begin
      w_sum = 0;
    end
`endif
    if (w_sum > SCORE_MAX) begin
      w_sum = SCORE_MAX;
    end
    w_score_next = SCORE_W'(w_sum);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, OVER: if (start) w_state_next = PLAY;
      PLAY:       if (w_last) w_state_next = OVER;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rnd   <= '0;
      r_map   <= '0;
      r_score <= '0;
    end else if (w_enter) begin
      r_cnt   <= '0;
      r_rnd   <= RND_W'(GAME_TICKS);
      r_map   <= '0;
      r_score <= '0;
    end else if (r_state == PLAY) begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_map   <= w_map_next;
      r_score <= w_score_next;
      if (w_tick) begin
        r_rnd <= r_rnd - 1'b1;
      end
    end
  end

  assign map       = r_map;
  assign score     = r_score;
  assign playing   = (r_state == PLAY);
  assign game_over = (r_state == OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl: a 20-tick round instance plus a 60-tick instance for saturation.
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [8:0] hit_a = '0, hit_b = '0;
  logic [8:0] map_a, map_b;
  logic [3:0] score_a, score_b;
  logic       playing_a, playing_b, go_a, go_b;

  always #5 clk = ~clk;

  mole_game_ctrl #(.TICK_DIV(4), .MOLE_LIFE(3), .GAME_TICKS(20), .SCORE_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .hit(hit_a),
    .map(map_a), .score(score_a), .playing(playing_a), .game_over(go_a)
  );

  mole_game_ctrl #(.TICK_DIV(4), .MOLE_LIFE(3), .GAME_TICKS(60), .SCORE_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .hit(hit_b),
    .map(map_b), .score(score_b), .playing(playing_b), .game_over(go_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference game state, index 0 = round of 20 ticks, 1 = round of 60 ticks.
  int         m_state [2];
  int         m_cnt   [2];
  int         m_rnd   [2];
  int         m_score [2];
  int         m_life  [2][9];
  int         spawns  [2];
  logic [8:0] m_map   [2];
  logic [8:0] m_lfsr = 9'h1A5;
  int         gt      [2] = '{20, 60};

  function automatic int pc(input logic [8:0] v);
    int c = 0;
    for (int i = 0; i < 9; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic sa, input logic sb,
                      input logic [8:0] ha, input logic [8:0] hb);
    logic [8:0] hv, nm;
    logic       st;
    int         ns, k;
    bit         tk;
    rst = r; start_a = sa; start_b = sb; hit_a = ha; hit_b = hb;
    k = int'(m_lfsr[3:0]);
    for (int d = 0; d < 2; d++) begin
      hv = (d == 0) ? ha : hb;
      st = (d == 0) ? sa : sb;
      if (r) begin
        m_state[d] = 0; m_cnt[d] = 0; m_rnd[d] = 0; m_map[d] = '0; m_score[d] = 0;
        for (int i = 0; i < 9; i++) m_life[d][i] = 0;
      end else if (m_state[d] != 1 && st) begin
        m_state[d] = 1; m_cnt[d] = 0; m_rnd[d] = gt[d]; m_map[d] = '0; m_score[d] = 0;
        spawns[d] = 0;
        for (int i = 0; i < 9; i++) m_life[d][i] = 0;
      end else if (m_state[d] == 1) begin
        ns = m_score[d] + pc(hv & m_map[d]);
`ifdef MISS_PENALTY_EN
        ns = ns - pc(hv & ~m_map[d]);
        if (ns < 0) ns = 0;
`endif
        if (ns > 15) ns = 15;
        nm = m_map[d] & ~hv;
        tk = (m_cnt[d] == 3);
        m_cnt[d] = tk ? 0 : m_cnt[d] + 1;
        if (tk) begin
          for (int i = 0; i < 9; i++) begin
            if (m_map[d][i]) begin
              if (m_life[d][i] == 1) nm[i] = 1'b0;
              else m_life[d][i]--;
            end
          end
          m_rnd[d]--;
          if (m_rnd[d] == 0) begin
            m_state[d] = 2;
            nm = '0;
          end else if (k < 9 && !nm[k]) begin
            nm[k] = 1'b1;
            m_life[d][k] = 3;
            spawns[d]++;
          end
        end
        m_map[d]   = nm;
        m_score[d] = ns;
      end
    end
    m_lfsr = r ? 9'h1A5 : {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    @(posedge clk);
    #1;
    check("map_a", map_a, m_map[0]);
    check("score_a", score_a, m_score[0]);
    check("playing_a", playing_a, m_state[0] == 1);
    check("game_over_a", go_a, m_state[0] == 2);
    check("map_b", map_b, m_map[1]);
    check("score_b", score_b, m_score[1]);
    check("playing_b", playing_b, m_state[1] == 1);
    check("game_over_b", go_b, m_state[1] == 2);
    $display("[TB] t=%0t rst=%b st=%b%b hitA=%h mapA=%h scA=%0d hitB=%h mapB=%h scB=%0d",
             $time, r, sa, sb, ha, map_a, score_a, hb, map_b, score_b);
  endtask

  initial begin
    int  prev, n, v, exp_sat;
    bit  done;

    // Reset and idle
    step(1'b1, 0, 0, '0, '0);
    step(1'b1, 0, 0, '0, '0);
    check("reset_map", map_a, 9'h000);
    check("reset_score", score_a, 4'd0);
    for (int i = 0; i < 50; i++) step(1'b0, 0, 0, '0, '0);
    step(1'b0, 0, 0, 9'h1FF, 9'h1FF);
    check("idle_hit_ignored", score_a, 4'd0);

    // Start both rounds
    step(1'b0, 1, 1, '0, '0);
    check("playing_after_start", playing_a, 1'b1);
    check("game_over_after_start", go_a, 1'b0);

    // A unattended: moles age out with no score; B whacks every mole it sees
    for (int i = 0; i < 24; i++) step(1'b0, 0, 0, '0, m_map[1]);
    check("no_hit_score_zero", score_a, 4'd0);

    // Hit two moles at once on A
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (pc(m_map[0]) >= 2) begin
        prev = m_score[0];
        n    = pc(m_map[0]);
        step(1'b0, 0, 0, m_map[0], m_map[1]);
        check("multi_hit_score", score_a, prev + n);
        done = 1;
      end else begin
        step(1'b0, 0, 0, '0, m_map[1]);
      end
    end

    // Miss on a vacant hole of A
    v = 0;
    for (int i = 8; i >= 0; i--) if (!m_map[0][i]) v = i;
    prev = m_score[0];
    step(1'b0, 0, 0, 9'(1 << v), m_map[1]);
`ifdef MISS_PENALTY_EN
    check("miss_score", score_a, (prev > 0) ? prev - 1 : 0);
`else
    check("miss_score", score_a, prev);
`endif

    // Run A to the end of its round
    prev = m_score[0];
    for (int i = 0; i < 200 && go_a !== 1'b1; i++) begin
      prev = m_score[0];
      step(1'b0, 0, 0, '0, m_map[1]);
    end
    check("over_flag", go_a, 1'b1);
    check("over_map_clear", map_a, 9'h000);
    check("over_score_held", score_a, prev);
    prev = m_score[0];
    step(1'b0, 0, 0, 9'h1FF, m_map[1]);
    check("over_hit_ignored", score_a, prev);

    // Run B to the end; its score must have saturated
    for (int i = 0; i < 400 && go_b !== 1'b1; i++) step(1'b0, 0, 0, '0, m_map[1]);
    check("b_over_flag", go_b, 1'b1);
    exp_sat = (spawns[1] >= 15) ? 15 : spawns[1];
    check("b_saturated_score", score_b, exp_sat);

    // Restart A from OVER, miss at score 0
    step(1'b0, 1, 0, '0, '0);
    check("restart_score", score_a, 4'd0);
    check("restart_playing", playing_a, 1'b1);
    check("restart_game_over", go_a, 1'b0);
    step(1'b0, 0, 0, 9'h001, '0);
    check("miss_at_zero", score_a, 4'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, '0, '0);

    // Reset mid-round
    step(1'b1, 0, 0, '0, '0);
    check("midrst_map", map_a, 9'h000);
    check("midrst_score", score_a, 4'd0);
    check("midrst_playing", playing_a, 1'b0);
    check("midrst_game_over", go_a, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 9'h1FF, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
